// File: rtl/fft_pkg.sv
// Shared types and address arithmetic for the radix-2 in-place DIT FFT sequencer.
// Defaults here are also used when instantiating the butterfly datapath.
package fft_pkg;

  localparam int FFT_LOG2N_DEF  = 4;
  localparam int FFT_BF_LAT_DEF = 4;
  localparam int FFT_ADDR_MAX   = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_ctrl_state_e;

  typedef struct packed {
    logic [FFT_ADDR_MAX-1:0] p;
    logic [FFT_ADDR_MAX-1:0] q;
    logic [FFT_ADDR_MAX-1:0] k;
  } bf_addr_t;

  // Operand pair and twiddle index for butterfly b of stage s; callers truncate.
  function automatic bf_addr_t bf_addr(input logic [31:0] log2n,
                                       input logic [31:0] s,
                                       input logic [31:0] b);
    logic [31:0] half;
    logic [31:0] pos;
    logic [31:0] grp;
    logic [31:0] p_full;
    bf_addr_t    r;
    half   = 32'd1 << s;
    pos    = b & (half - 32'd1);
    grp    = b >> s;
    p_full = (grp << (s + 32'd1)) | pos;
    r.p    = FFT_ADDR_MAX'(p_full);
    r.q    = FFT_ADDR_MAX'(p_full + half);
    r.k    = FFT_ADDR_MAX'(pos << (log2n - 32'd1 - s));
    return r;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Valid+payload shift register of fixed depth; output is the oldest entry.
module fft_delay_line #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  always_comb begin
    valid_d[0] = in_valid;
    data_d[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly sequencer for the in-place DIT FFT: read addresses, twiddle index,
// and write-back addresses delayed to line up with the RAM + butterfly latency.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N  = FFT_LOG2N_DEF,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = FFT_BF_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(LOG2N):0]    stage,
  output logic                      rd_en,
  output logic [LOG2N-1:0]          rd_addr_p,
  output logic [LOG2N-1:0]          rd_addr_q,
  output logic [LOG2N-2:0]          tw_addr,
  output logic                      wr_en,
  output logic [LOG2N-1:0]          wr_addr_p,
  output logic [LOG2N-1:0]          wr_addr_q,
  output fft_ctrl_state_e           dbg_state
);

  localparam int PIPE_LAT = RD_LAT + BF_LAT;
  localparam int SW       = $clog2(LOG2N) + 1;
  localparam int BW       = LOG2N - 1;
  localparam int DW       = $clog2(PIPE_LAT + 1);
  localparam logic [BW-1:0] B_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  fft_ctrl_state_e state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [BW-1:0]    b_q, b_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] rd_p_q, rd_p_d;
  logic [LOG2N-1:0] rd_qa_q, rd_qa_d;
  logic [LOG2N-2:0] tw_q, tw_d;
  bf_addr_t         addr;

  // Outputs are registered by decoding the next state, so they line up with state_q.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    b_d     = b_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        stage_d = '0;
        b_d     = '0;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (b_q == B_LAST) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == D_LAST) begin
          if (stage_q == S_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 1'b1;
            b_d     = '0;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == RUN) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
    rd_en_d = (state_d == RUN);
    addr    = bf_addr(32'(LOG2N), 32'(stage_d), 32'(b_d));
    rd_p_d  = rd_en_d ? addr.p[LOG2N-1:0] : '0;
    rd_qa_d = rd_en_d ? addr.q[LOG2N-1:0] : '0;
    tw_d    = rd_en_d ? addr.k[LOG2N-2:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      b_q     <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_p_q  <= '0;
      rd_qa_q <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      b_q     <= b_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      rd_p_q  <= rd_p_d;
      rd_qa_q <= rd_qa_d;
      tw_q    <= tw_d;
    end
  end

  logic [2*LOG2N-1:0] wr_data;

  fft_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (2*LOG2N)
  ) u_wr_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_en_q),
    .in_data   ({rd_p_q, rd_qa_q}),
    .out_valid (wr_en),
    .out_data  (wr_data)
  );

  assign wr_addr_p = wr_data[2*LOG2N-1:LOG2N];
  assign wr_addr_q = wr_data[LOG2N-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = stage_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_p = rd_p_q;
  assign rd_addr_q = rd_qa_q;
  assign tw_addr   = tw_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Scoreboard bench for fft_stage_ctrl at LOG2N=3, RD_LAT=1, BF_LAT=4 (PIPE_LAT=5).
module tb_fft_stage_ctrl;
  import fft_pkg::*;

  localparam int LOG2N  = 3;
  localparam int RD_LAT = 1;
  localparam int BF_LAT = 4;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            busy;
  logic            done;
  logic [2:0]      stage;
  logic            rd_en;
  logic [2:0]      rd_addr_p;
  logic [2:0]      rd_addr_q;
  logic [1:0]      tw_addr;
  logic            wr_en;
  logic [2:0]      wr_addr_p;
  logic [2:0]      wr_addr_q;
  fft_ctrl_state_e dbg_state;

  fft_stage_ctrl #(.LOG2N(LOG2N), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr_p (rd_addr_p),
    .rd_addr_q (rd_addr_q),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_p (wr_addr_p),
    .wr_addr_q (wr_addr_q),
    .dbg_state (dbg_state)
  );

  // Clock/reset block and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // Scoreboard state
  typedef struct packed {
    logic [15:0] cyc;
    logic [2:0]  stage;
    logic [2:0]  p;
    logic [2:0]  q;
    logic [1:0]  k;
  } rd_ev_t;

  typedef struct packed {
    logic [15:0] cyc;
    logic [2:0]  p;
    logic [2:0]  q;
  } wr_ev_t;

  rd_ev_t      exp_rd_q[$];
  wr_ev_t      exp_wr_q[$];
  logic [15:0] exp_done_q[$];
  logic [31:0] busy_win_q[$];
  logic [7:0]  rd_tbl [12];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic miss(input string name, input int exp_cyc);
    checks++;
    errors++;
    $display("FAIL %s: event expected at cycle %0d not seen (now %0d)", name, exp_cyc, cyc);
  endtask

  // Expected responses for a transform whose start is sampled in cycle t
  task automatic push_expected(input int t);
    rd_ev_t e;
    wr_ev_t w;
    for (int s = 0; s < 3; s++) begin
      for (int b = 0; b < 4; b++) begin
        e.cyc   = 16'(t + 1 + 9*s + b);
        e.stage = 3'(s);
        {e.p, e.q, e.k} = rd_tbl[s*4 + b];
        exp_rd_q.push_back(e);
        w.cyc = e.cyc + 16'd5;
        w.p   = e.p;
        w.q   = e.q;
        exp_wr_q.push_back(w);
      end
    end
    exp_done_q.push_back(16'(t + 28));
    busy_win_q.push_back({16'(t + 1), 16'(t + 27)});
  endtask

  task automatic flush_expected();
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_done_q.delete();
    busy_win_q.delete();
  endtask

  // Driver tasks
  task automatic start_transform(output int t);
    @(negedge clk);
    t = cyc;
    start = 1'b1;
    push_expected(t);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((exp_rd_q.size() + exp_wr_q.size() + exp_done_q.size()) > 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if ((exp_rd_q.size() + exp_wr_q.size() + exp_done_q.size()) > 0) begin
      miss("timeout_wait_idle", cyc);
      flush_expected();
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_stage", 32'(stage), 32'd0);
    chk("idle_rd_en", 32'(rd_en), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_stage"}, 32'(stage), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_p"},  32'(rd_addr_p), 32'd0);
    chk({tag, "_rd_q"},  32'(rd_addr_q), 32'd0);
    chk({tag, "_tw"},    32'(tw_addr), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_p"},  32'(wr_addr_p), 32'd0);
    chk({tag, "_wr_q"},  32'(wr_addr_q), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // Monitor: pops expected events whenever the DUT presents a read, write or done
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_busy;
      rd_ev_t e;
      wr_ev_t w;
      logic [15:0] d;
      while (exp_rd_q.size() > 0 && int'(exp_rd_q[0].cyc) < cyc) begin
        miss("rd_missing", int'(exp_rd_q[0].cyc));
        void'(exp_rd_q.pop_front());
      end
      while (exp_wr_q.size() > 0 && int'(exp_wr_q[0].cyc) < cyc) begin
        miss("wr_missing", int'(exp_wr_q[0].cyc));
        void'(exp_wr_q.pop_front());
      end
      while (exp_done_q.size() > 0 && int'(exp_done_q[0]) < cyc) begin
        miss("done_missing", int'(exp_done_q[0]));
        void'(exp_done_q.pop_front());
      end
      if (rd_en) begin
        if (exp_rd_q.size() == 0) begin
          chk("rd_unexpected", 32'(rd_en), 32'd0);
        end else begin
          e = exp_rd_q.pop_front();
          chk("rd_cycle", 32'(cyc), 32'(e.cyc));
          chk("rd_stage", 32'(stage), 32'(e.stage));
          chk("rd_addr_p", 32'(rd_addr_p), 32'(e.p));
          chk("rd_addr_q", 32'(rd_addr_q), 32'(e.q));
          chk("tw_addr", 32'(tw_addr), 32'(e.k));
        end
      end
      if (wr_en) begin
        if (exp_wr_q.size() == 0) begin
          chk("wr_unexpected", 32'(wr_en), 32'd0);
        end else begin
          w = exp_wr_q.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(w.cyc));
          chk("wr_addr_p", 32'(wr_addr_p), 32'(w.p));
          chk("wr_addr_q", 32'(wr_addr_q), 32'(w.q));
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          d = exp_done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(d));
          chk("done_stage", 32'(stage), 32'd2);
        end
      end
      exp_busy = 1'b0;
      foreach (busy_win_q[i]) begin
        if (cyc >= int'(busy_win_q[i][31:16]) && cyc <= int'(busy_win_q[i][15:0])) exp_busy = 1'b1;
      end
      chk("busy", 32'(busy), 32'(exp_busy));
      // No read/write collision is possible in this configuration
      chk("rd_wr_same_cycle", 32'(rd_en & wr_en), 32'd0);
    end
  end

  // Stimulus
  initial begin
    int t;
    int seen;
    rd_tbl[0]  = {3'd0, 3'd1, 2'd0};
    rd_tbl[1]  = {3'd2, 3'd3, 2'd0};
    rd_tbl[2]  = {3'd4, 3'd5, 2'd0};
    rd_tbl[3]  = {3'd6, 3'd7, 2'd0};
    rd_tbl[4]  = {3'd0, 3'd2, 2'd0};
    rd_tbl[5]  = {3'd1, 3'd3, 2'd2};
    rd_tbl[6]  = {3'd4, 3'd6, 2'd0};
    rd_tbl[7]  = {3'd5, 3'd7, 2'd2};
    rd_tbl[8]  = {3'd0, 3'd4, 2'd0};
    rd_tbl[9]  = {3'd1, 3'd5, 2'd1};
    rd_tbl[10] = {3'd2, 3'd6, 2'd2};
    rd_tbl[11] = {3'd3, 3'd7, 2'd3};

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain transform
    start_transform(t);
    wait_idle(60);
    idle_check();

    // Start pulses during a transform are ignored
    start_transform(t);
    while (cyc < t + 5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t + 15) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(60);
    idle_check();

    // Asynchronous abort in cycle 12
    start_transform(t);
    do begin
      @(posedge clk);
      #2;
    end while (cyc < t + 12);
    rst_n = 1'b0;
    #1;
    flush_expected();
    check_all_zero("abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rd_en || wr_en) seen++;
    end
    chk("quiet_after_abort", 32'(seen), 32'd0);

    // Fresh transform after abort
    start_transform(t);
    wait_idle(60);
    idle_check();

    // start held high: back-to-back transforms
    @(negedge clk);
    t = cyc;
    start = 1'b1;
    push_expected(t);
    push_expected(t + 29);
    while (cyc < t + 31) @(negedge clk);
    start = 1'b0;
    wait_idle(100);
    idle_check();

    chk("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
    chk("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_done_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_stage_ctrl.md
Name: fft_stage_ctrl

Overview:
- Sequencer for the radix-2 butterfly datapath of the in-place DIT FFT (N = 2^LOG2N points; data pre-stored in bit-reversed order).
- Per stage, issues one butterfly per cycle:
  - read addresses for the p/q operands;
  - twiddle ROM address;
  - latency-matched write-back addresses and write enable.
- Sits between the top-level FFT FSM (start/done) and the data RAM, twiddle ROM and butterfly. Carries no data itself.

Parameters:
- LOG2N, 4: log2 of FFT size; N = 2^LOG2N, range 2..12.
- RD_LAT, 1: data RAM and twiddle ROM read latency in cycles.
- BF_LAT, 4: butterfly input-to-output latency in cycles (fixed register depth of the butterfly).
- Derived constant: PIPE_LAT = RD_LAT + BF_LAT.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: begin transform; sampled only in IDLE.
- busy, out, 1: high from the cycle after start acceptance until done.
- done, out, 1: one-cycle pulse after the final write-back.
- stage, out, $clog2(LOG2N)+1: current stage index s.
- rd_en, out, 1: operand/twiddle read strobe.
- rd_addr_p, out, LOG2N: upper operand address.
- rd_addr_q, out, LOG2N: lower operand address.
- tw_addr, out, LOG2N-1: twiddle ROM index k for W_N^k.
- wr_en, out, 1: write-back strobe for butterfly results.
- wr_addr_p, out, LOG2N: yp destination address.
- wr_addr_q, out, LOG2N: yq destination address.

Behaviour:
- Reset (async): state=IDLE, stage=0, butterfly counter b=0, drain counter=0, write pipeline valid bits cleared. All outputs 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: if start=1 → RUN, s=0, b=0, busy=1.
  - RUN: rd_en=1 every cycle. b increments. At b=N/2-1 → DRAIN, drain counter=0.
  - DRAIN: rd_en=0 for PIPE_LAT cycles, so all writes of stage s retire before stage s+1 reads.
    - If s<LOG2N-1: → RUN with s+1, b=0.
    - Else → DONE.
  - DONE: done=1 and busy=0 for one cycle → IDLE.
- Address arithmetic, combinational from (s, b):
  - half = 1<<s; pos = b & (half-1); grp = b >> s.
  - rd_addr_p = (grp << (s+1)) | pos.
  - rd_addr_q = rd_addr_p + half.
  - tw_addr = pos << (LOG2N-1-s).
  - All values unsigned, truncated to port width. No overflow is possible by construction.
- Write pipeline:
  - Shift register, PIPE_LAT deep, carrying {rd_en, rd_addr_p, rd_addr_q}.
  - wr_en, wr_addr_p and wr_addr_q are its output, so a write occurs exactly PIPE_LAT cycles after the matching read.
- Timing (start sampled in cycle 0):
  - first rd_en in cycle 1;
  - each stage occupies N/2 + PIPE_LAT cycles;
  - done pulses in cycle 1 + LOG2N*(N/2+PIPE_LAT).
- Final write of stage s and first read of stage s+1 are never in the same cycle (1-cycle gap). The RAM needs no read-during-write bypass.
- start while busy: ignored, no restart.
- start held high through DONE: a new transform is accepted in the following IDLE cycle.
- rst_n asserted mid-transform: immediate abort. No partial wr_en after release. The RAM contents are undefined to the caller.
- stage output holds the last value (LOG2N-1) through DRAIN/DONE and returns to 0 in IDLE.

Decomposition:
- Package fft_pkg:
  - typedef fft_ctrl_state_e (IDLE/RUN/DRAIN/DONE);
  - function bf_addr(s, b) returning the {p, q, k} struct;
  - default LOG2N/BF_LAT constants shared with the butterfly instantiation.
- Sub-module fft_delay_line:
  - generic parameterised valid+payload shift register (DEPTH, WIDTH);
  - reused for the write pipeline and elsewhere.

Test Plan (LOG2N=3, RD_LAT=1, BF_LAT=4; start pulsed in cycle 0):
1. Start from reset → rd_en in cycles 1–4 with (p,q,k) = (0,1,0),(2,3,0),(4,5,0),(6,7,0); stage=0; wr_en cycles 6–9 with the same p/q.
2. Stage 1 → reads in cycles 10–13: (0,2,0),(1,3,2),(4,6,0),(5,7,2). Stage 2 → reads in cycles 19–22: (0,4,0),(1,5,1),(2,6,2),(3,7,3).
3. Completion → last wr_en in cycle 27 (p=3, q=7); done=1 only in cycle 28; busy high cycles 1–27. No cycle has wr_addr equal to a same-cycle rd_addr across stage boundaries.
4. start pulsed in cycles 5 and 15 during a transform → no effect; sequence identical to scenarios 1–3.
5. rst_n low in cycle 12 → all outputs 0 asynchronously. After release with no start: no rd_en/wr_en for 40 cycles. A new start yields sequence 1 again.
6. start held high continuously → back-to-back transforms; second transform's first rd_en in cycle 30; done pulses in cycles 28 and 57.
